// File: rtl/axi4_mem_arbiter_pkg.sv
// Shared types and AXI constants for the IFU/LSU memory-port arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } arb_state_e;

    typedef enum logic {
        M_IFU = 1'b0,
        M_LSU = 1'b1
    } master_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi4_mem_arbiter_if.sv
// AXI4 read (AR+R) and write (AW+W+B) channel bundles, each with master/slave views.
interface axi4_rd_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [ID_W-1:0]   rid;
    logic              rlast;
    logic [1:0]        rresp;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rid, rlast, rresp
    );
    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rid, rlast, rresp
    );
endinterface

interface axi4_wr_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
);
    logic                awvalid;
    logic                awready;
    logic [ADDR_W-1:0]   awaddr;
    logic [ID_W-1:0]     awid;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
               wvalid, wdata, wstrb, wlast, bready,
        input  awready, wready, bvalid, bid, bresp
    );
    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
               wvalid, wdata, wstrb, wlast, bready,
        output awready, wready, bvalid, bid, bresp
    );
endinterface

// File: rtl/axi4_mem_arbiter_rr_pick.sv
// Two-input round-robin picker: a lone request wins, a tie goes to the master not granted last.
module axi_rr_pick
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  master_e    last,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == M_IFU) ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/axi4_mem_arbiter.sv
// Shares the io_master AXI4 port between IFU refills and LSU single-beat accesses,
// one transaction at a time, and drains IFU bursts abandoned by a flush.
module axi4_mem_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ID_W      = 4,
    parameter bit          LSU_FIRST = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    axi4_rd_if.slave    ifu,
    input  logic        ifu_flush,
    axi4_rd_if.slave    lsu_rd,
    axi4_wr_if.slave    lsu_wr,
    axi4_rd_if.master   io_master_rd,
    axi4_wr_if.master   io_master_wr,
    output logic [1:0]  arb_state
);

    arb_state_e state;
    master_e    last_grant;
    logic       ar_done, aw_done, w_done, drain;

    logic ifu_own, lsu_rd_own, wr_own;
    logic flush_early, drain_now, ifu_r_route, b_open;
    logic [1:0] req, grant;

    assign ifu_own    = (state == IFU_RD);
    assign lsu_rd_own = (state == LSU_RD);
    assign wr_own     = (state == LSU_WR);

    assign req = {lsu_rd.arvalid | lsu_wr.awvalid, ifu.arvalid};

    axi_rr_pick u_pick (
        .req   (req),
        .last  (last_grant),
        .grant (grant)
    );

    // A flush after AR acceptance turns the rest of the burst into a drain the IFU never sees.
    assign flush_early = ifu_own & ifu_flush & ~ar_done;
    assign drain_now   = ifu_own & (drain | (ifu_flush & ar_done));
    assign ifu_r_route = ifu_own & ~drain_now;

    logic              ar_valid_sel;
    logic [ADDR_W-1:0] ar_addr_sel;
    logic [ID_W-1:0]   ar_id_sel;
    logic [7:0]        ar_len_sel;
    logic [2:0]        ar_size_sel;
    logic [1:0]        ar_burst_sel;

    always_comb begin
        ar_valid_sel = 1'b0;
        ar_addr_sel  = '0;
        ar_id_sel    = '0;
        ar_len_sel   = '0;
        ar_size_sel  = '0;
        ar_burst_sel = '0;
        if (ifu_own) begin
            ar_valid_sel = ifu.arvalid & ~ar_done & ~ifu_flush;
            ar_addr_sel  = ifu.araddr;
            ar_id_sel    = ifu.arid;
            ar_len_sel   = ifu.arlen;
            ar_size_sel  = ifu.arsize;
            ar_burst_sel = ifu.arburst;
        end else if (lsu_rd_own) begin
            ar_valid_sel = lsu_rd.arvalid & ~ar_done;
            ar_addr_sel  = lsu_rd.araddr;
            ar_id_sel    = lsu_rd.arid;
            ar_len_sel   = lsu_rd.arlen;
            ar_size_sel  = lsu_rd.arsize;
            ar_burst_sel = lsu_rd.arburst;
        end
    end

    assign io_master_rd.arvalid = ar_valid_sel;
    assign io_master_rd.araddr  = ar_addr_sel;
    assign io_master_rd.arid    = ar_id_sel;
    assign io_master_rd.arlen   = ar_len_sel;
    assign io_master_rd.arsize  = ar_size_sel;
    assign io_master_rd.arburst = ar_burst_sel;
    assign io_master_rd.rready  = ifu_own ? (drain_now | ifu.rready) : (lsu_rd_own & lsu_rd.rready);

    assign ifu.arready = ifu_own & ~ar_done & ~ifu_flush & io_master_rd.arready;
    assign ifu.rvalid  = ifu_r_route & io_master_rd.rvalid;
    assign ifu.rdata   = ifu_r_route ? io_master_rd.rdata : '0;
    assign ifu.rid     = ifu_r_route ? io_master_rd.rid   : '0;
    assign ifu.rlast   = ifu_r_route & io_master_rd.rlast;
    assign ifu.rresp   = ifu_r_route ? io_master_rd.rresp : '0;

    assign lsu_rd.arready = lsu_rd_own & ~ar_done & io_master_rd.arready;
    assign lsu_rd.rvalid  = lsu_rd_own & io_master_rd.rvalid;
    assign lsu_rd.rdata   = lsu_rd_own ? io_master_rd.rdata : '0;
    assign lsu_rd.rid     = lsu_rd_own ? io_master_rd.rid   : '0;
    assign lsu_rd.rlast   = lsu_rd_own & io_master_rd.rlast;
    assign lsu_rd.rresp   = lsu_rd_own ? io_master_rd.rresp : '0;

    logic [DATA_W-1:0] w_data_sel;
    assign w_data_sel = wr_own ? lsu_wr.wdata : '0;

    assign io_master_wr.awvalid = wr_own & ~aw_done & lsu_wr.awvalid;
    assign io_master_wr.awaddr  = wr_own ? lsu_wr.awaddr  : '0;
    assign io_master_wr.awid    = wr_own ? lsu_wr.awid    : '0;
    assign io_master_wr.awlen   = wr_own ? lsu_wr.awlen   : '0;
    assign io_master_wr.awsize  = wr_own ? lsu_wr.awsize  : '0;
    assign io_master_wr.awburst = wr_own ? lsu_wr.awburst : '0;
    assign io_master_wr.wvalid  = wr_own & ~w_done & lsu_wr.wvalid;
    assign io_master_wr.wdata   = w_data_sel;
    assign io_master_wr.wstrb   = wr_own ? lsu_wr.wstrb : '0;
    assign io_master_wr.wlast   = wr_own & lsu_wr.wlast;

    // B is only opened once both address and last data beat have been accepted.
    assign b_open = wr_own & aw_done & w_done;
    assign io_master_wr.bready = b_open & lsu_wr.bready;
    assign lsu_wr.awready = wr_own & ~aw_done & io_master_wr.awready;
    assign lsu_wr.wready  = wr_own & ~w_done & io_master_wr.wready;
    assign lsu_wr.bvalid  = b_open & io_master_wr.bvalid;
    assign lsu_wr.bid     = b_open ? io_master_wr.bid   : '0;
    assign lsu_wr.bresp   = b_open ? io_master_wr.bresp : '0;

    logic ar_hs, r_end;
    assign ar_hs = io_master_rd.arvalid & io_master_rd.arready;
    assign r_end = io_master_rd.rvalid & io_master_rd.rready & io_master_rd.rlast;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= LSU_FIRST ? M_IFU : M_LSU;
            ar_done    <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            drain      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ar_done <= 1'b0;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    drain   <= 1'b0;
                    if (grant[0]) begin
                        state      <= IFU_RD;
                        last_grant <= M_IFU;
                    end else if (grant[1]) begin
                        state      <= lsu_wr.awvalid ? LSU_WR : LSU_RD;
                        last_grant <= M_LSU;
                    end
                end
                IFU_RD: begin
                    if (flush_early) begin
                        state <= IDLE;
                    end else begin
                        if (ar_hs)     ar_done <= 1'b1;
                        if (drain_now) drain   <= 1'b1;
                        if (r_end)     state   <= IDLE;
                    end
                end
                LSU_RD: begin
                    if (ar_hs) ar_done <= 1'b1;
                    if (r_end) state   <= IDLE;
                end
                LSU_WR: begin
                    if (io_master_wr.awvalid & io_master_wr.awready) aw_done <= 1'b1;
                    if (io_master_wr.wvalid & io_master_wr.wready & io_master_wr.wlast) w_done <= 1'b1;
                    if (io_master_wr.bvalid & io_master_wr.bready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign arb_state = state;

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// Directed bench for axi4_mem_arbiter: a bus-ownership model checked every cycle plus literal spot checks.
module tb_axi4_mem_arbiter;
    import axi_arb_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ifu_flush;
    logic [1:0] arb_state;

    axi4_rd_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) ifu_if  ();
    axi4_rd_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) lsur_if ();
    axi4_wr_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) lsuw_if ();
    axi4_rd_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) iord_if ();
    axi4_wr_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) iowr_if ();

    axi4_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .LSU_FIRST(1'b0)) dut (
        .clock        (clock),
        .reset        (reset),
        .ifu          (ifu_if),
        .ifu_flush    (ifu_flush),
        .lsu_rd       (lsur_if),
        .lsu_wr       (lsuw_if),
        .io_master_rd (iord_if),
        .io_master_wr (iowr_if),
        .arb_state    (arb_state)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus (0 none, 1 IFU read, 2 LSU read, 3 LSU write) and what has been sent.
    int m_owner = 0;
    bit m_addr_sent = 0, m_data_sent = 0, m_drain = 0, m_tie_ifu = 1;
    int n_ar_hs = 0, n_aw_hs = 0, n_w_hs = 0, n_ifu_rvalid = 0, n_rd_beats = 0, n_arvalid_cyc = 0;

    always @(negedge clock) begin : model
        bit own_i, own_r, own_w, fl_early, drain_now, ireq, lreq;
        bit e_arvalid, e_ifu_arready, e_lsu_arready, e_rready, e_ifu_rvalid, e_lsu_rvalid;
        bit e_awvalid, e_wvalid, e_bvalid, e_bready;
        logic [31:0] e_araddr;
        own_i = (m_owner == 1);
        own_r = (m_owner == 2);
        own_w = (m_owner == 3);
        fl_early  = own_i && ifu_flush && !m_addr_sent;
        drain_now = own_i && (m_drain || (ifu_flush && m_addr_sent));
        e_arvalid = own_i ? (ifu_if.arvalid && !m_addr_sent && !ifu_flush)
                  : own_r ? (lsur_if.arvalid && !m_addr_sent) : 1'b0;
        e_araddr  = own_i ? ifu_if.araddr : own_r ? lsur_if.araddr : 32'h0;
        e_ifu_arready = own_i && !m_addr_sent && !ifu_flush && iord_if.arready;
        e_lsu_arready = own_r && !m_addr_sent && iord_if.arready;
        e_rready      = own_i ? (drain_now || ifu_if.rready) : (own_r && lsur_if.rready);
        e_ifu_rvalid  = own_i && !drain_now && iord_if.rvalid;
        e_lsu_rvalid  = own_r && iord_if.rvalid;
        e_awvalid     = own_w && !m_addr_sent && lsuw_if.awvalid;
        e_wvalid      = own_w && !m_data_sent && lsuw_if.wvalid;
        e_bvalid      = own_w && m_addr_sent && m_data_sent && iowr_if.bvalid;
        e_bready      = own_w && m_addr_sent && m_data_sent && lsuw_if.bready;

        if (chk_en) begin
            chk("state", arb_state, m_owner);
            chk("io_arvalid", iord_if.arvalid, e_arvalid);
            chk("io_araddr", iord_if.araddr, e_araddr);
            chk("ifu_arready", ifu_if.arready, e_ifu_arready);
            chk("lsu_arready", lsur_if.arready, e_lsu_arready);
            chk("io_rready", iord_if.rready, e_rready);
            chk("ifu_rvalid", ifu_if.rvalid, e_ifu_rvalid);
            chk("lsu_rvalid", lsur_if.rvalid, e_lsu_rvalid);
            chk("io_awvalid", iowr_if.awvalid, e_awvalid);
            chk("io_wvalid", iowr_if.wvalid, e_wvalid);
            chk("lsu_bvalid", lsuw_if.bvalid, e_bvalid);
            chk("io_bready", iowr_if.bready, e_bready);
        end

        if (iord_if.arvalid && iord_if.arready) n_ar_hs++;
        if (iord_if.arvalid) n_arvalid_cyc++;
        if (iowr_if.awvalid && iowr_if.awready) n_aw_hs++;
        if (iowr_if.wvalid && iowr_if.wready) n_w_hs++;
        if (ifu_if.rvalid) n_ifu_rvalid++;
        if (iord_if.rvalid && iord_if.rready) n_rd_beats++;

        if (reset) begin
            m_owner = 0; m_addr_sent = 0; m_data_sent = 0; m_drain = 0; m_tie_ifu = 1;
        end else begin
            case (m_owner)
                0: begin
                    ireq = ifu_if.arvalid;
                    lreq = lsur_if.arvalid || lsuw_if.awvalid;
                    m_addr_sent = 0; m_data_sent = 0; m_drain = 0;
                    if (ireq && (!lreq || m_tie_ifu)) begin
                        m_owner = 1; m_tie_ifu = 0;
                    end else if (lreq) begin
                        m_owner = lsuw_if.awvalid ? 3 : 2; m_tie_ifu = 1;
                    end
                end
                1: begin
                    if (fl_early) m_owner = 0;
                    else begin
                        if (e_arvalid && iord_if.arready) m_addr_sent = 1;
                        if (drain_now) m_drain = 1;
                        if (iord_if.rvalid && e_rready && iord_if.rlast) m_owner = 0;
                    end
                end
                2: begin
                    if (e_arvalid && iord_if.arready) m_addr_sent = 1;
                    if (iord_if.rvalid && e_rready && iord_if.rlast) m_owner = 0;
                end
                default: begin
                    if (e_awvalid && iowr_if.awready) m_addr_sent = 1;
                    if (e_wvalid && iowr_if.wready && lsuw_if.wlast) m_data_sent = 1;
                    if (iowr_if.bvalid && e_bready) m_owner = 0;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic init_inputs();
        ifu_flush = 0;
        ifu_if.arvalid = 0; ifu_if.araddr = '0; ifu_if.arid = '0; ifu_if.arlen = '0;
        ifu_if.arsize = SIZE_4B; ifu_if.arburst = BURST_INCR; ifu_if.rready = 0;
        lsur_if.arvalid = 0; lsur_if.araddr = '0; lsur_if.arid = '0; lsur_if.arlen = '0;
        lsur_if.arsize = SIZE_4B; lsur_if.arburst = BURST_INCR; lsur_if.rready = 0;
        lsuw_if.awvalid = 0; lsuw_if.awaddr = '0; lsuw_if.awid = '0; lsuw_if.awlen = '0;
        lsuw_if.awsize = SIZE_4B; lsuw_if.awburst = BURST_INCR;
        lsuw_if.wvalid = 0; lsuw_if.wdata = '0; lsuw_if.wstrb = '0; lsuw_if.wlast = 0; lsuw_if.bready = 0;
        iord_if.arready = 0; iord_if.rvalid = 0; iord_if.rdata = '0; iord_if.rid = '0;
        iord_if.rlast = 0; iord_if.rresp = RESP_OKAY;
        iowr_if.awready = 0; iowr_if.wready = 0; iowr_if.bvalid = 0; iowr_if.bid = '0; iowr_if.bresp = RESP_OKAY;
    endtask

    int c0, c1;

    initial begin
        init_inputs();
        reset = 1;
        tick();
        chk("rst_state", arb_state, 0);
        chk("rst_io_arvalid", iord_if.arvalid, 0);
        chk("rst_io_araddr", iord_if.araddr, 0);
        chk("rst_io_awvalid", iowr_if.awvalid, 0);
        chk("rst_io_wdata", iowr_if.wdata, 0);
        chk("rst_io_rready", iord_if.rready, 0);
        tick();
        reset = 0;
        chk_en = 1;

        // Lone IFU refill burst
        ifu_if.arvalid = 1; ifu_if.araddr = 32'h3000_0010; ifu_if.arid = 4'h3; ifu_if.arlen = 8'd3;
        #1 chk("t1_not_yet", iord_if.arvalid, 0);
        tick();
        chk("t1_state", arb_state, 1);
        chk("t1_araddr", iord_if.araddr, 32'h3000_0010);
        chk("t1_arid", iord_if.arid, 4'h3);
        chk("t1_arlen", iord_if.arlen, 8'd3);
        iord_if.arready = 1;
        tick();
        ifu_if.arvalid = 0; iord_if.arready = 0; ifu_if.rready = 1;
        c0 = n_ifu_rvalid;
        for (int i = 0; i < 4; i++) begin
            iord_if.rvalid = 1; iord_if.rdata = 32'hA000_0000 + i; iord_if.rid = 4'h3; iord_if.rlast = (i == 3);
            #1 chk("t1_rdata", ifu_if.rdata, 32'hA000_0000 + i);
            chk("t1_lsu_rvalid", lsur_if.rvalid, 0);
            tick();
        end
        iord_if.rvalid = 0; iord_if.rlast = 0; ifu_if.rready = 0;
        chk("t1_beats", n_ifu_rvalid - c0, 4);
        chk("t1_idle", arb_state, 0);

        // Tie right after reset: IFU first, then LSU wins the next tie
        reset = 1; tick(); reset = 0;
        ifu_if.arvalid = 1; ifu_if.araddr = 32'h3000_0100; ifu_if.arlen = 8'd0;
        lsur_if.arvalid = 1; lsur_if.araddr = 32'h1000_0004; lsur_if.arid = 4'h7;
        tick();
        chk("t2_ifu_first", arb_state, 1);
        chk("t2_ifu_addr", iord_if.araddr, 32'h3000_0100);
        iord_if.arready = 1; tick(); iord_if.arready = 0;
        ifu_if.araddr = 32'h3000_0200; ifu_if.rready = 1;
        iord_if.rvalid = 1; iord_if.rlast = 1; iord_if.rdata = 32'h1111_2222;
        tick();
        iord_if.rvalid = 0; iord_if.rlast = 0;
        chk("t2_idle_gap", arb_state, 0);
        tick();
        chk("t2_lsu_second", arb_state, 2);
        chk("t2_lsu_addr", iord_if.araddr, 32'h1000_0004);
        chk("t2_lsu_arid", iord_if.arid, 4'h7);
        iord_if.arready = 1; tick(); iord_if.arready = 0; lsur_if.arvalid = 0;
        lsur_if.rready = 1; iord_if.rvalid = 1; iord_if.rlast = 1; iord_if.rdata = 32'h3333_4444;
        tick();
        iord_if.rvalid = 0; iord_if.rlast = 0; lsur_if.rready = 0;
        tick();
        chk("t2_ifu_again", arb_state, 1);
        chk("t2_ifu_addr2", iord_if.araddr, 32'h3000_0200);
        iord_if.arready = 1; tick(); iord_if.arready = 0; ifu_if.arvalid = 0;
        iord_if.rvalid = 1; iord_if.rlast = 1;
        tick();
        iord_if.rvalid = 0; iord_if.rlast = 0; ifu_if.rready = 0;

        // LSU write with W arriving two cycles before AW
        c0 = n_aw_hs; c1 = n_w_hs;
        lsuw_if.wvalid = 1; lsuw_if.wdata = 32'hDEAD_BEEF; lsuw_if.wstrb = 4'hF; lsuw_if.wlast = 1;
        tick(); tick();
        chk("t3_w_held", iowr_if.wvalid, 0);
        lsuw_if.awvalid = 1; lsuw_if.awaddr = 32'h8000_0000; lsuw_if.awid = 4'h5;
        tick();
        chk("t3_state", arb_state, 3);
        chk("t3_awaddr", iowr_if.awaddr, 32'h8000_0000);
        chk("t3_wdata", iowr_if.wdata, 32'hDEAD_BEEF);
        chk("t3_wstrb", iowr_if.wstrb, 4'hF);
        iowr_if.awready = 1; iowr_if.wready = 1;
        ifu_if.arvalid = 1; ifu_if.araddr = 32'h3000_0040; ifu_if.arlen = 8'd3;
        tick();
        lsuw_if.awvalid = 0; lsuw_if.wvalid = 0; iowr_if.awready = 0; iowr_if.wready = 0;
        iowr_if.bvalid = 1; iowr_if.bid = 4'h5; iowr_if.bresp = RESP_OKAY; lsuw_if.bready = 1;
        #1 chk("t3_bvalid", lsuw_if.bvalid, 1);
        chk("t3_bid", lsuw_if.bid, 4'h5);
        chk("t3_bresp", lsuw_if.bresp, RESP_OKAY);
        tick();
        iowr_if.bvalid = 0; lsuw_if.bready = 0;
        chk("t3_one_aw", n_aw_hs - c0, 1);
        chk("t3_one_w", n_w_hs - c1, 1);
        chk("t3_idle", arb_state, 0);

        // Flush after AR accepted: burst is drained, pending LSU read follows
        lsur_if.arvalid = 1; lsur_if.araddr = 32'h1000_0040;
        tick();
        chk("t4_ifu_owner", arb_state, 1);
        iord_if.arready = 1; tick(); iord_if.arready = 0; ifu_if.arvalid = 0;
        c0 = n_ifu_rvalid; c1 = n_rd_beats;
        ifu_flush = 1;
        for (int i = 0; i < 4; i++) begin
            iord_if.rvalid = 1; iord_if.rdata = 32'hB000_0000 + i; iord_if.rlast = (i == 3);
            #1 chk("t4_drain_rready", iord_if.rready, 1);
            tick();
            ifu_flush = 0;
        end
        iord_if.rvalid = 0; iord_if.rlast = 0;
        chk("t4_no_ifu_rvalid", n_ifu_rvalid - c0, 0);
        chk("t4_drained", n_rd_beats - c1, 4);
        chk("t4_idle", arb_state, 0);
        tick();
        chk("t4_lsu_next", arb_state, 2);
        chk("t4_lsu_addr", iord_if.araddr, 32'h1000_0040);
        iord_if.arready = 1; tick(); iord_if.arready = 0; lsur_if.arvalid = 0;
        lsur_if.rready = 1; iord_if.rvalid = 1; iord_if.rlast = 1;
        tick();
        iord_if.rvalid = 0; iord_if.rlast = 0; lsur_if.rready = 0;

        // Flush before the AR could be issued
        c0 = n_arvalid_cyc; c1 = n_ar_hs;
        ifu_if.arvalid = 1; ifu_if.araddr = 32'h3000_0080; ifu_flush = 1;
        tick();
        chk("t5_granted", arb_state, 1);
        tick();
        chk("t5_back_idle", arb_state, 0);
        ifu_if.arvalid = 0; ifu_flush = 0;
        tick();
        chk("t5_no_arvalid", n_arvalid_cyc - c0, 0);
        chk("t5_no_ar_hs", n_ar_hs - c1, 0);
        chk("t5_still_idle", arb_state, 0);

        // Reset during R beat 2, then the waiting LSU read completes
        ifu_if.arvalid = 1; ifu_if.araddr = 32'h3000_00C0; ifu_if.arlen = 8'd3;
        tick();
        lsur_if.arvalid = 1; lsur_if.araddr = 32'h2000_0008; lsur_if.arid = 4'h2;
        iord_if.arready = 1; tick(); iord_if.arready = 0; ifu_if.arvalid = 0;
        ifu_if.rready = 1; iord_if.rvalid = 1; iord_if.rdata = 32'hC000_0000;
        tick();
        iord_if.rdata = 32'hC000_0001; reset = 1;
        tick();
        chk("t6_state", arb_state, 0);
        chk("t6_arvalid", iord_if.arvalid, 0);
        chk("t6_ifu_rvalid", ifu_if.rvalid, 0);
        chk("t6_rready", iord_if.rready, 0);
        reset = 0; iord_if.rvalid = 0; ifu_if.rready = 0;
        tick();
        chk("t6_lsu_retry", arb_state, 2);
        chk("t6_lsu_addr", iord_if.araddr, 32'h2000_0008);
        iord_if.arready = 1; tick(); iord_if.arready = 0; lsur_if.arvalid = 0;
        lsur_if.rready = 1; iord_if.rvalid = 1; iord_if.rlast = 1;
        iord_if.rdata = 32'h1234_5678; iord_if.rid = 4'h2; iord_if.rresp = 2'b10;
        #1 chk("t6_lsu_rdata", lsur_if.rdata, 32'h1234_5678);
        chk("t6_lsu_rresp", lsur_if.rresp, 2'b10);
        tick();
        iord_if.rvalid = 0; iord_if.rlast = 0; lsur_if.rready = 0; iord_if.rresp = RESP_OKAY;
        chk("t6_done", arb_state, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
